// File: rtl/datapath.sv
// datapath: accumulator datapath with 32x8 program/data memory, IR, PC, A and MDR.
// Define DATAPATH_OVF_EN to enable the sticky signed-overflow flag on Ovf.
module datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic       IRload,
  input  logic       JMPmux,
  input  logic       PCload,
  input  logic       Meminst,
  input  logic       MenWr,
  input  logic       Aload,
  input  logic       Sub,
  input  logic       Halt,
  input  logic [1:0] Asel,
  input  logic [7:0] Input,
  input  logic       prog_we,
  input  logic [4:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [2:0] IR,
  output logic       Aeq0,
  output logic       Apos,
  output logic [7:0] Output,
  output logic [4:0] PC,
  output logic       Ovf
);
  logic [7:0] mem_q [32];
  logic [7:0] ir_q, a_q, mdr_q, a_d, rd, sum;
  logic [4:0] pc_q, pc_d, addr;
  assign addr = Meminst ? ir_q[4:0] : pc_q;
  assign rd   = mem_q[addr];
  assign sum  = Sub ? a_q - mdr_q : a_q + mdr_q;
  assign a_d  = Asel == 2'd0 ? sum : Asel == 2'd1 ? Input : Asel == 2'd2 ? mdr_q : 8'h00;
  assign pc_d = JMPmux ? ir_q[4:0] : pc_q + 5'd1;
  assign IR     = ir_q[7:5];
  assign Aeq0   = a_q == 8'h00;
  assign Apos   = !a_q[7] && a_q != 8'h00;
  assign Output = a_q;
  assign PC     = pc_q;
  // Programs enter only while reset is held; normal writes store A.
  always_ff @(posedge clk)
    if (reset ? prog_we : MenWr && !Halt)
      mem_q[reset ? prog_addr : addr] <= reset ? prog_data : a_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q  <= 8'h00;
      pc_q  <= 5'd0;
      a_q   <= 8'h00;
      mdr_q <= 8'h00;
    end else if (!Halt) begin
      if (IRload) ir_q <= rd;
      if (PCload) pc_q <= pc_d;
      if (Meminst) mdr_q <= rd;
      if (Aload) a_q <= a_d;
    end
  end
`ifdef DATAPATH_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = (a_q[7] ^ mdr_q[7] ^ ~Sub) & (a_q[7] ^ sum[7]);
  always_ff @(posedge clk)
    if (reset) ovf_q <= 1'b0;
    else if (!Halt && Aload && Asel == 2'd0 && ovf_d) ovf_q <= 1'b1;
  assign Ovf = ovf_q;
`else
  assign Ovf = 1'b0;
`endif
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed-vector bench for datapath with hand-computed expectations.
module tb_datapath;
  logic clk = 0, reset = 0, IRload = 0, JMPmux = 0, PCload = 0, Meminst = 0;
  logic MenWr = 0, Aload = 0, Sub = 0, Halt = 0, prog_we = 0;
  logic [1:0] Asel = 0;
  logic [7:0] in_v = 0, prog_data = 0;
  logic [4:0] prog_addr = 0;
  logic [2:0] IR;
  logic Aeq0, Apos, Ovf;
  logic [7:0] out_v;
  logic [4:0] PC;
  int checks = 0, errors = 0;
`ifdef DATAPATH_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif
  datapath dut (
    .clk(clk), .reset(reset), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MenWr(MenWr), .Aload(Aload), .Sub(Sub), .Halt(Halt),
    .Asel(Asel), .Input(in_v), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Output(out_v),
    .PC(PC), .Ovf(Ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
    {reset, IRload, JMPmux, PCload, Meminst, MenWr, Aload, Sub, Halt, prog_we} = '0;
    Asel = 0;
  endtask
  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    reset = 1; prog_we = 1; prog_addr = a; prog_data = d;
    cyc();
  endtask
  task automatic load_in(input logic [7:0] v);
    in_v = v; Aload = 1; Asel = 2'd1;
    cyc();
  endtask
  initial begin
    prog(5'd0, 8'h83); prog(5'd1, 8'h45); prog(5'd2, 8'hAC); prog(5'd3, 8'h29);
    prog(5'd5, 8'h10); prog(5'd9, 8'h77); prog(5'd12, 8'h01);
    chk("rst_pc", 8'(PC), 8'd0); chk("rst_ir", 8'(IR), 8'd0); chk("rst_a", out_v, 8'h00);
    chk("rst_aeq0", 8'(Aeq0), 8'd1); chk("rst_apos", 8'(Apos), 8'd0); chk("rst_ovf", 8'(Ovf), 8'd0);
    prog_we = 1; prog_addr = 5'd0; prog_data = 8'hFF;
    IRload = 1; PCload = 1; cyc();
    chk("fetch_ir", 8'(IR), 8'd4); chk("fetch_pc", 8'(PC), 8'd1);
    load_in(8'h22);
    chk("ld_in", out_v, 8'h22);
    IRload = 1; PCload = 1; cyc();
    chk("fetch2_ir", 8'(IR), 8'd2); chk("fetch2_pc", 8'(PC), 8'd2);
    Meminst = 1; cyc();
    Aload = 1; Sub = 1; cyc();
    chk("sub_a", out_v, 8'h12); chk("sub_aeq0", 8'(Aeq0), 8'd0); chk("sub_apos", 8'(Apos), 8'd1);
    Aload = 1; Asel = 2'd2; cyc();
    chk("ld_mdr", out_v, 8'h10);
    Aload = 1; Asel = 2'd3; cyc();
    chk("ld_zero", out_v, 8'h00); chk("zero_aeq0", 8'(Aeq0), 8'd1);
    IRload = 1; PCload = 1; cyc();
    chk("fetch3_ir", 8'(IR), 8'd5); chk("fetch3_pc", 8'(PC), 8'd3);
    PCload = 1; JMPmux = 1; cyc();
    chk("jmp_pc", 8'(PC), 8'd12);
    load_in(8'h7F);
    Meminst = 1; cyc();
    Aload = 1; cyc();
    chk("ovf_a", out_v, 8'h80); chk("ovf_apos", 8'(Apos), 8'd0); chk("ovf_flag", 8'(Ovf), 8'(OVF_EXP));
    Aload = 1; Asel = 2'd3; cyc();
    chk("ovf_sticky", 8'(Ovf), 8'(OVF_EXP));
    for (int i = 0; i < 19; i++) begin PCload = 1; cyc(); end
    chk("pc_31", 8'(PC), 8'd31);
    PCload = 1; cyc();
    chk("pc_wrap", 8'(PC), 8'd0);
    for (int i = 0; i < 3; i++) begin PCload = 1; cyc(); end
    IRload = 1; cyc();
    chk("fetch4_ir", 8'(IR), 8'd1);
    load_in(8'h5A);
    Meminst = 1; MenWr = 1; cyc();
    Aload = 1; Asel = 2'd2; cyc();
    chk("wr_preread", out_v, 8'h77);
    Meminst = 1; cyc();
    Aload = 1; Asel = 2'd2; cyc();
    chk("wr_mem9", out_v, 8'h5A);
    load_in(8'h66);
    Halt = 1; Meminst = 1; MenWr = 1; Aload = 1; Asel = 2'd1; in_v = 8'h11;
    IRload = 1; PCload = 1; cyc();
    chk("halt_a", out_v, 8'h66); chk("halt_pc", 8'(PC), 8'd3); chk("halt_ir", 8'(IR), 8'd1);
    Meminst = 1; cyc();
    Aload = 1; Asel = 2'd2; cyc();
    chk("halt_mem9", out_v, 8'h5A);
    load_in(8'h33);
    for (int i = 0; i < 4; i++) begin PCload = 1; cyc(); end
    chk("pre_rst_pc", 8'(PC), 8'd7);
    reset = 1; Aload = 1; Asel = 2'd1; in_v = 8'h44; PCload = 1; IRload = 1; cyc();
    chk("mid_rst_a", out_v, 8'h00); chk("mid_rst_pc", 8'(PC), 8'd0);
    chk("mid_rst_ir", 8'(IR), 8'd0); chk("mid_rst_ovf", 8'(Ovf), 8'd0);
    IRload = 1; cyc();
    chk("mem_kept", 8'(IR), 8'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: IRload, JMPmux, PCload, Meminst, MenWr, Aload, Sub, Halt  input  1 each  control strobes from the control unit.
REQ-004 SHALL: Asel  input  2  accumulator source select.
REQ-005 SHALL: Input  input  8  user data word.
REQ-006 SHALL: prog_we  input  1; prog_addr  input  5; prog_data  input  8  program-load port.
REQ-007 SHALL: IR  output  3  opcode, equal to IR register bits [7:5].
REQ-008 SHALL: Aeq0  output  1  accumulator equals zero; Apos  output  1  accumulator strictly positive (signed).
REQ-009 SHALL: Output  output  8  accumulator value; PC  output  5  program counter.
REQ-010 SHALL: Ovf  output  1  sticky signed-overflow flag (see Configuration).

Function
REQ-011 SHALL: state = 32x8 memory, 8-bit IR register, 5-bit PC, 8-bit accumulator A, 8-bit memory data register MDR.
REQ-012 SHALL: memory address = Meminst ? IRreg[4:0] : PC; memory read is combinational, write is synchronous.
REQ-013 SHALL: IRload=1 -> IRreg <= mem[address] on the same edge (fetch completes in one cycle).
REQ-014 SHALL: PCload=1 and JMPmux=0 -> PC <= PC+1, wrapping 31 -> 0.
REQ-015 SHALL: PCload=1 and JMPmux=1 -> PC <= IRreg[4:0]; IRload and PCload together use pre-edge PC for both.
REQ-016 SHALL: Meminst=1 -> MDR <= mem[address] every edge; MDR otherwise holds.
REQ-017 SHALL: MenWr=1 -> mem[address] <= A; same-cycle read returns pre-write data.
REQ-018 SHALL: Aload=1 -> A <= source per Asel: 00 = A+MDR (Sub=0) or A-MDR (Sub=1), mod 256; 01 = Input; 10 = MDR; 11 = 8'h00.
REQ-019 SHALL: Aeq0 = (A==0); Apos = (A[7]==0 and A!=0); both combinational from A.
REQ-020 SHALL: Halt=1 -> suppress IRload, PCload, MenWr, Aload effects; all state holds while Halt high.
REQ-021 SHALL: prog_we ignored when reset=0.

Reset
REQ-022 SHALL: reset=1 at an edge -> PC=0, IRreg=0, A=0, MDR=0, Ovf=0; overrides every control strobe, including mid-instruction.
REQ-023 SHALL: memory contents not cleared by reset.
REQ-024 SHALL: reset=1 and prog_we=1 -> mem[prog_addr] <= prog_data; only path to preload programs.

Configuration
REQ-025 SHALL: macro DATAPATH_OVF_EN defined -> Ovf set when Aload=1, Asel=00, and the add/sub signed-overflows; sticky until reset.
REQ-026 SHALL: DATAPATH_OVF_EN undefined -> Ovf port present, tied 0, no overflow logic.

Verification
REQ-027 SHALL: preload mem[0]=8'h83 (input), reset low, IRload+PCload one cycle -> IR=3'b100, PC=1, IRreg=8'h83.
REQ-028 SHALL: mem[5]=8'h10, IRreg=8'h45, A=8'h22: Meminst cycle then Aload Asel=00 Sub=1 -> A=8'h12, Aeq0=0, Apos=1.
REQ-029 SHALL: PC=31, PCload=1 JMPmux=0 -> PC=0; IRreg=8'hAC, PCload=1 JMPmux=1 -> PC=12.
REQ-030 SHALL: A=8'h7F, MDR=8'h01, Aload Asel=00 Sub=0 -> A=8'h80, Apos=0, Ovf=1 with DATAPATH_OVF_EN, Ovf=0 without.
REQ-031 SHALL: IRreg=8'h29, A=8'h5A, Meminst=1 MenWr=1 -> mem[9]=8'h5A; same with Halt=1 -> mem[9] unchanged.
REQ-032 SHALL: A=8'h33, PC=7, reset pulsed one cycle during Aload -> A=0, PC=0, preloaded memory intact.
